// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - word-organised MEM-stage data memory with valid/ready port and configurable latency
module data_memory_ctrl #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          LATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_byte,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        log_valid,
  output logic [31:0] log_pc,
  output logic [31:0] log_addr,
  output logic [31:0] log_data
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int          DEPTH = 1 << ADDR_WIDTH;
  localparam int          CW    = $clog2(LATENCY + 2);
  localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      byte_q, byte_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     pc_q, pc_d;
  logic            rsp_err_q, rsp_err_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            log_valid_q, log_valid_d;
  logic [31:0]     log_pc_q, log_pc_d;
  logic [31:0]     log_addr_q, log_addr_d;
  logic [31:0]     log_data_q, log_data_d;
  logic [31:0]     mem_q [DEPTH];

  logic                  accept, do_access, in_range, wr_en;
  logic                  cur_we;
  logic [31:0]           cur_addr, cur_wdata, cur_pc, old_word, aligned, merged;
  logic [3:0]            cur_byte;
  logic [32:0]           offset;
  logic [ADDR_WIDTH-1:0] idx;

  function automatic logic [31:0] align_lanes(input logic [3:0] mask, input logic [31:0] w);
    case (mask)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: align_lanes = {4{w[7:0]}};
      4'b0011, 4'b1100:                   align_lanes = {2{w[15:0]}};
      default:                            align_lanes = w;
    endcase
  endfunction

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    // With zero latency the access happens on the accept edge, straight from the inputs.
    if (state_q == IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_byte  = req_byte;
      cur_wdata = req_wdata;
      cur_pc    = req_pc;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_byte  = byte_q;
      cur_wdata = wdata_q;
      cur_pc    = pc_q;
    end
    offset   = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
    in_range = (cur_addr >= BASE_ADDR) && (offset < SPAN);
    idx      = offset[ADDR_WIDTH+1:2];
    old_word = mem_q[idx];
    aligned  = align_lanes(cur_byte, cur_wdata);
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = cur_byte[i] ? aligned[8*i +: 8] : old_word[8*i +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    byte_d      = byte_q;
    wdata_d     = wdata_q;
    pc_d        = pc_q;
    do_access   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          byte_d  = req_byte;
          wdata_d = req_wdata;
          pc_d    = req_pc;
          // The counter counts remaining WAIT cycles beyond the current one.
          cnt_d   = (LATENCY > 0) ? CW'(LATENCY - 1) : '0;
          if (LATENCY == 0) begin
            do_access = 1'b1;
            state_d   = RESP;
          end else begin
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          do_access = 1'b1;
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    log_valid_d = 1'b0;
    log_pc_d    = log_pc_q;
    log_addr_d  = log_addr_q;
    log_data_d  = log_data_q;
    wr_en       = do_access && in_range && cur_we && (cur_byte != 4'b0000);
    if (do_access) begin
      rsp_err_d   = !in_range;
      rsp_rdata_d = !in_range ? 32'h0 : (cur_we ? merged : old_word);
    end
    if (wr_en) begin
      log_valid_d = 1'b1;
      log_pc_d    = cur_pc;
      log_addr_d  = {cur_addr[31:2], 2'b00};
      log_data_d  = merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      byte_q      <= '0;
      wdata_q     <= '0;
      pc_q        <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      log_valid_q <= 1'b0;
      log_pc_q    <= '0;
      log_addr_q  <= '0;
      log_data_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      byte_q      <= byte_d;
      wdata_q     <= wdata_d;
      pc_q        <= pc_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      log_valid_q <= log_valid_d;
      log_pc_q    <= log_pc_d;
      log_addr_q  <= log_addr_d;
      log_data_q  <= log_data_d;
      if (wr_en) mem_q[idx] <= merged;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign log_valid = log_valid_q;
  assign log_pc    = log_pc_q;
  assign log_addr  = log_addr_q;
  assign log_data  = log_data_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - self-checking bench for data_memory_ctrl at latencies 1, 3 and 0
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  vld;
  logic        req_we;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic [3:0]  req_byte;

  logic [2:0]  rdy, rv, err, lv;
  logic [31:0] rdata [3];
  logic [31:0] lpc   [3];
  logic [31:0] laddr [3];
  logic [31:0] ldata [3];

  int checks = 0;
  int failures = 0;
  int lat [3] = '{1, 3, 0};

  logic [31:0] m [3][4096];
  logic [31:0] e_lpc [3];
  logic [31:0] e_laddr [3];
  logic [31:0] e_ldata [3];

  always #5 clk = ~clk;

  data_memory_ctrl #(.LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req_valid(vld[0]), .req_ready(rdy[0]), .req_we(req_we),
    .req_addr(req_addr), .req_byte(req_byte), .req_wdata(req_wdata), .req_pc(req_pc),
    .rsp_valid(rv[0]), .rsp_err(err[0]), .rsp_rdata(rdata[0]), .log_valid(lv[0]),
    .log_pc(lpc[0]), .log_addr(laddr[0]), .log_data(ldata[0]));

  data_memory_ctrl #(.LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .req_valid(vld[1]), .req_ready(rdy[1]), .req_we(req_we),
    .req_addr(req_addr), .req_byte(req_byte), .req_wdata(req_wdata), .req_pc(req_pc),
    .rsp_valid(rv[1]), .rsp_err(err[1]), .rsp_rdata(rdata[1]), .log_valid(lv[1]),
    .log_pc(lpc[1]), .log_addr(laddr[1]), .log_data(ldata[1]));

  data_memory_ctrl #(.LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .req_valid(vld[2]), .req_ready(rdy[2]), .req_we(req_we),
    .req_addr(req_addr), .req_byte(req_byte), .req_wdata(req_wdata), .req_pc(req_pc),
    .rsp_valid(rv[2]), .rsp_err(err[2]), .rsp_rdata(rdata[2]), .log_valid(lv[2]),
    .log_pc(lpc[2]), .log_addr(laddr[2]), .log_data(ldata[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < 4096; w++) m[d][w] = 32'h0;
      e_lpc[d] = 0; e_laddr[d] = 0; e_ldata[d] = 0;
    end
  endtask

  // Reference: lane i of a store takes byte (i mod span) of wdata, span being the width the mask implies.
  task automatic model(input int d, input logic we, input logic [31:0] addr, input logic [3:0] mask,
                       input logic [31:0] wdata, input logic [31:0] pc,
                       output logic e_err, output logic [31:0] e_rd, output logic e_log);
    int span;
    logic [31:0] word;
    e_log = 1'b0;
    if (addr >= 32'h4000) begin
      e_err = 1'b1; e_rd = 32'h0;
      return;
    end
    e_err = 1'b0;
    word  = m[d][addr / 4];
    if (!we) begin
      e_rd = word;
      return;
    end
    span = ($countones(mask) == 1) ? 1 : ((mask == 4'b0011 || mask == 4'b1100) ? 2 : 4);
    for (int i = 0; i < 4; i++)
      if (mask[i]) word[8*i +: 8] = wdata[8*(i % span) +: 8];
    e_rd = word;
    if (mask != 4'b0000) begin
      m[d][addr / 4] = word;
      e_log = 1'b1;
      e_lpc[d] = pc; e_laddr[d] = addr & ~32'h3; e_ldata[d] = word;
    end
  endtask

  task automatic check_rsp(input int d, input logic e_err, input logic [31:0] e_rd, input logic e_log);
    check("rsp_err", 32'(err[d]), 32'(e_err));
    check("rsp_rdata", rdata[d], e_rd);
    check("log_valid", 32'(lv[d]), 32'(e_log));
    check("log_pc", lpc[d], e_lpc[d]);
    check("log_addr", laddr[d], e_laddr[d]);
    check("log_data", ldata[d], e_ldata[d]);
  endtask

  // Called at a negedge with the target instance idle; returns at the negedge after the response.
  task automatic txn(input int d, input logic we, input logic [31:0] addr, input logic [3:0] mask,
                     input logic [31:0] wdata, input logic [31:0] pc);
    logic e_err, e_log;
    logic [31:0] e_rd;
    int k;
    k = 0;
    while (!rdy[d] && k < 20) begin @(negedge clk); k++; end
    check("ready_before_req", 32'(rdy[d]), 32'd1);
    req_we = we; req_addr = addr; req_byte = mask; req_wdata = wdata; req_pc = pc;
    vld[d] = 1'b1;
    model(d, we, addr, mask, wdata, pc, e_err, e_rd, e_log);
    @(negedge clk);
    vld[d] = 1'b0;
    req_we = 1'($urandom); req_addr = $urandom; req_byte = 4'($urandom);
    req_wdata = $urandom; req_pc = $urandom;
    k = 1;
    while (!rv[d] && k < 20) begin
      check("ready_low_in_wait", 32'(rdy[d]), 32'd0);
      check("no_log_in_wait", 32'(lv[d]), 32'd0);
      @(negedge clk);
      k++;
    end
    check("rsp_latency", 32'(k), 32'(lat[d] + 1));
    check("ready_low_in_resp", 32'(rdy[d]), 32'd0);
    check_rsp(d, e_err, e_rd, e_log);
    @(negedge clk);
    check("rsp_one_cycle", 32'(rv[d]), 32'd0);
    check("log_one_cycle", 32'(lv[d]), 32'd0);
    check("ready_after_resp", 32'(rdy[d]), 32'd1);
    check("rdata_hold", rdata[d], e_rd);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
  endtask

  initial begin
    logic e_err, e_log;
    logic [31:0] e_rd, a;
    reset = 1'b1; vld = 3'b000;
    req_we = 0; req_addr = 0; req_byte = 0; req_wdata = 0; req_pc = 0;
    @(negedge clk);
    do_reset();
    for (int d = 0; d < 3; d++) begin
      check("reset_ready", 32'(rdy[d]), 32'd1);
      check("reset_rsp_valid", 32'(rv[d]), 32'd0);
      check_rsp(d, 1'b0, 32'h0, 1'b0);
    end

    txn(0, 1'b0, 32'h10, 4'b1111, 32'h0, 32'h100);
    txn(0, 1'b1, 32'h10, 4'b1111, 32'h12345678, 32'h104);
    check("plan_store_word", ldata[0], 32'h12345678);
    txn(0, 1'b1, 32'h12, 4'b0100, 32'h000000AB, 32'h108);
    check("plan_sb_log", ldata[0], 32'h12AB5678);
    check("plan_sb_addr", laddr[0], 32'h10);
    txn(0, 1'b0, 32'h10, 4'b0000, 32'h0, 32'h10C);
    check("plan_load", rdata[0], 32'h12AB5678);
    txn(0, 1'b1, 32'h22, 4'b1100, 32'h0000BEEF, 32'h110);
    check("plan_sh_hi", rdata[0], 32'hBEEF0000);
    txn(0, 1'b1, 32'h20, 4'b0011, 32'h00001234, 32'h114);
    check("plan_sh_lo", ldata[0], 32'hBEEF1234);
    txn(0, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, 32'h118);
    txn(0, 1'b1, 32'h24, 4'b1010, 32'hA1B2C3D4, 32'h11C);
    txn(0, 1'b0, 32'h4000, 4'b1111, 32'h0, 32'h120);
    txn(0, 1'b1, 32'h4000, 4'b1111, 32'hDEADBEEF, 32'h124);
    txn(0, 1'b1, 32'hFFFF_FFFC, 4'b1111, 32'hDEADBEEF, 32'h128);
    txn(0, 1'b1, 32'h3FFC, 4'b1111, 32'hCAFEF00D, 32'h12C);
    txn(0, 1'b0, 32'h3FFF, 4'b0000, 32'h0, 32'h130);
    check("plan_top_word", rdata[0], 32'hCAFEF00D);

    txn(1, 1'b1, 32'h0, 4'b1111, 32'h0BADF00D, 32'h200);
    // Reset during the second WAIT cycle of a LATENCY=3 store drops it entirely.
    req_we = 1'b1; req_addr = 32'h0; req_byte = 4'b1111; req_wdata = 32'hFFFFFFFF; req_pc = 32'h204;
    vld[1] = 1'b1;
    @(negedge clk);
    vld[1] = 1'b0;
    check("rst_wait1_rv", 32'(rv[1]), 32'd0);
    @(negedge clk);
    check("rst_wait2_rv", 32'(rv[1]), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    for (int c = 0; c < 4; c++) begin
      check("rst_drop_rv", 32'(rv[1]), 32'd0);
      check("rst_drop_lv", 32'(lv[1]), 32'd0);
      check("rst_drop_ready", 32'(rdy[1]), 32'd1);
      @(negedge clk);
    end
    check_rsp(1, 1'b0, 32'h0, 1'b0);
    txn(1, 1'b0, 32'h0, 4'b1111, 32'h0, 32'h208);
    check("rst_load_zero", rdata[1], 32'h0);

    // LATENCY=0 with req_valid held: ready alternates and every other cycle accepts.
    vld[2] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      a = {18'h0, 4'($urandom_range(0, 3)), 8'($urandom), 2'b00};
      if (j == 5) a = 32'h4004;
      req_we = (j % 2 == 0); req_addr = a; req_byte = 4'($urandom);
      req_wdata = $urandom; req_pc = 32'h300 + 32'(j);
      model(2, req_we, req_addr, req_byte, req_wdata, req_pc, e_err, e_rd, e_log);
      check("held_ready_1", 32'(rdy[2]), 32'd1);
      @(negedge clk);
      check("held_ready_0", 32'(rdy[2]), 32'd0);
      check("held_rv", 32'(rv[2]), 32'd1);
      check_rsp(2, e_err, e_rd, e_log);
      if (j == 5) vld[2] = 1'b0;
      @(negedge clk);
    end

    for (int n = 0; n < 80; n++) begin
      int d;
      d = (n % 2 == 0) ? 0 : 2;
      a = {20'h0, 4'($urandom_range(0, 15)), 2'b00, 2'($urandom)};
      if ($urandom_range(0, 9) == 0) a = 32'h4000 + ($urandom & 32'hFFFF);
      txn(d, 1'($urandom), a, 4'($urandom), $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
